// File: rtl/mod_mult_pipe.sv
// mod_mult_pipe: 3-stage pipelined Barrett modular multiplier, (a*b) mod Q.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/a/b/in_tag in;
//   out_valid/out_ready/result/out_tag out; busy = any stage holds a beat.
// Option: define MOD_MULT_RANGE_CHECK_EN to add range_err (a or b >= Q).
module mod_mult_pipe #(
    parameter int          WIDTH = 32,
    parameter int unsigned Q     = 3329,
    parameter int          TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] out_tag,
`ifdef MOD_MULT_RANGE_CHECK_EN
    output logic             range_err,
`endif
    output logic             busy
);

    localparam int K   = $clog2(Q);
    localparam int PW  = 2 * WIDTH;
    localparam int MW  = K + 1;
    localparam int XW  = PW + MW;
    localparam int W2K = 2 * K + 1;

    // MU = floor(2^(2K) / Q); always < 2^(K+1) because Q > 2^(K-1).
    localparam logic [W2K-1:0] POW2K   = {1'b1, {(2 * K){1'b0}}};
    localparam logic [W2K-1:0] MU_FULL = POW2K / W2K'(Q);
    localparam logic [MW-1:0]  MU      = MW'(MU_FULL);
    localparam logic [PW-1:0]  QP      = PW'(Q);
    localparam logic [WIDTH-1:0] QV    = WIDTH'(Q);

    logic             en;
    logic [PW-1:0]    prod;
    logic [XW-1:0]    pm;
    logic [PW-1:0]    qh;
    logic [PW-1:0]    r0, r1, r2;
    logic [WIDTH-1:0] res_next;

    logic             s1_v, s2_v;
    logic [PW-1:0]    s1_p, s2_p, s2_qh;
    logic [TAG_W-1:0] s1_tag, s2_tag;

    // Whole pipe moves as one; a stalled output freezes every stage.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign busy     = s1_v || s2_v || out_valid;

    assign prod = PW'(a) * PW'(b);
    assign pm   = XW'(s1_p) * XW'(MU);
    assign qh   = PW'(pm >> (2 * K));

    // qhat never exceeds p/Q, so r0 cannot underflow; it is < 3Q here.
    assign r0 = s2_p - s2_qh * QP;
    assign r1 = (r0 >= QP) ? r0 - QP : r0;
    assign r2 = (r1 >= QP) ? r1 - QP : r1;

`ifdef MOD_MULT_RANGE_CHECK_EN
    logic in_err, s1_err, s2_err;

    assign in_err   = (a >= QV) || (b >= QV);
    assign res_next = s2_err ? '0 : WIDTH'(r2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_err    <= 1'b0;
            s2_err    <= 1'b0;
            range_err <= 1'b0;
        end else if (en) begin
            s1_err    <= in_err;
            s2_err    <= s1_err;
            range_err <= s2_err;
        end
    end
`else
    assign res_next = WIDTH'(r2);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s1_p      <= '0;
            s1_tag    <= '0;
            s2_v      <= 1'b0;
            s2_p      <= '0;
            s2_qh     <= '0;
            s2_tag    <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            out_tag   <= '0;
        end else if (en) begin
            s1_v      <= in_valid;
            s1_p      <= prod;
            s1_tag    <= in_tag;
            s2_v      <= s1_v;
            s2_p      <= s1_p;
            s2_qh     <= qh;
            s2_tag    <= s1_tag;
            out_valid <= s2_v;
            result    <= res_next;
            out_tag   <= s2_tag;
        end
    end

endmodule

// File: tb/tb_mod_mult_pipe.sv
// tb_mod_mult_pipe: directed checks of mod_mult_pipe (WIDTH=32, Q=3329).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mod_mult_pipe;

    localparam int          WIDTH = 32;
    localparam int unsigned Q     = 3329;
    localparam int          TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
`ifdef MOD_MULT_RANGE_CHECK_EN
    logic             range_err;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mod_mult_pipe #(.WIDTH(WIDTH), .Q(Q), .TAG_W(TAG_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .out_tag  (out_tag),
`ifdef MOD_MULT_RANGE_CHECK_EN
        .range_err(range_err),
`endif
        .busy     (busy)
    );

    // Sends one beat into an empty pipe and waits for its result.
    // lat = number of post-edge samples until out_valid (-1 on timeout).
    task automatic run_one(input logic [WIDTH-1:0] va,
                           input logic [WIDTH-1:0] vb,
                           input logic [TAG_W-1:0] vt,
                           output logic [WIDTH-1:0] r,
                           output logic [TAG_W-1:0] t,
                           output int lat,
                           output logic err);
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = va;
        b = vb;
        in_tag = vt;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        r   = result;
        t   = out_tag;
        lat = out_valid ? n : -1;
`ifdef MOD_MULT_RANGE_CHECK_EN
        err = range_err;
`else
        err = 1'b0;
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        in_tag = '0;
        out_ready = 1'b0;
        #2;
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL reset_ctrl: out_valid=%b busy=%b in_ready=%b, want 0 0 1",
                     out_valid, busy, in_ready);
        end else pass_cnt++;
        total_cnt++;
        if (result !== '0 || out_tag !== '0) begin
            $display("FAIL reset_data: result=%0d tag=%h, want 0 00", result, out_tag);
        end else pass_cnt++;
`ifdef MOD_MULT_RANGE_CHECK_EN
        total_cnt++;
        if (range_err !== 1'b0) begin
            $display("FAIL reset_range_err: got %b want 0", range_err);
        end else pass_cnt++;
`endif
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] r;
        logic [TAG_W-1:0] t;
        int lat;
        logic e;
        total_cnt++;
        if (in_ready !== 1'b1) begin
            $display("FAIL basic_in_ready: got %b want 1", in_ready);
        end else pass_cnt++;
        run_one(17, 1234, 8'h5A, r, t, lat, e);
        total_cnt++;
        if (r !== 1004) $display("FAIL basic_result: got %0d want 1004", r);
        else pass_cnt++;
        total_cnt++;
        if (t !== 8'h5A) $display("FAIL basic_tag: got %h want 5a", t);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 3) $display("FAIL basic_latency: got %0d want 3", lat);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL basic_idle_busy: got %b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_edges();
        logic [WIDTH-1:0] r;
        logic [TAG_W-1:0] t;
        int lat;
        logic e;
        run_one(3328, 3328, 8'h11, r, t, lat, e);
        total_cnt++;
        if (r !== 1 || t !== 8'h11) begin
            $display("FAIL max_operands: result=%0d tag=%h, want 1 11", r, t);
        end else pass_cnt++;
        run_one(0, 3000, 8'h22, r, t, lat, e);
        total_cnt++;
        if (r !== 0 || t !== 8'h22) begin
            $display("FAIL zero_operand: result=%0d tag=%h, want 0 22", r, t);
        end else pass_cnt++;
        run_one(100, 100, 8'h23, r, t, lat, e);
        total_cnt++;
        if (r !== 13) $display("FAIL mid_operands: got %0d want 13", r);
        else pass_cnt++;
        run_one(1, 1, 8'h24, r, t, lat, e);
        total_cnt++;
        if (r !== 1 || lat !== 3) begin
            $display("FAIL unit_operands: result=%0d lat=%0d, want 1 3", r, lat);
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp_r[$];
        logic [TAG_W-1:0] exp_t[$];
        int got = 0;
        int first = -1;
        int last = -1;
        int nrdy = 0;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [WIDTH-1:0] ra, rb;
                    longint unsigned pr;
                    ra = $urandom_range(0, Q - 1);
                    rb = $urandom_range(0, Q - 1);
                    pr = (longint'(ra) * longint'(rb)) % Q;
                    exp_r.push_back(WIDTH'(pr));
                    exp_t.push_back(TAG_W'(i));
                    a = ra;
                    b = rb;
                    in_tag = TAG_W'(i);
                    in_valid = 1'b1;
                    if (!in_ready) nrdy++;
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 1200; c++) begin
                    @(posedge clk); #1;
                    if (out_valid) begin
                        if (first < 0) first = c;
                        last = c;
                        total_cnt++;
                        if (exp_r.size() == 0) begin
                            $display("FAIL b2b_extra: result=%0d with nothing expected", result);
                        end else begin
                            logic [WIDTH-1:0] er;
                            logic [TAG_W-1:0] et;
                            er = exp_r.pop_front();
                            et = exp_t.pop_front();
                            if (result !== er || out_tag !== et) begin
                                $display("FAIL b2b_beat%0d: result=%0d tag=%h, want %0d %h",
                                         got, result, out_tag, er, et);
                            end else pass_cnt++;
                        end
                        got++;
                    end
                    if (got == 1000) break;
                end
            end
        join
        total_cnt++;
        if (got !== 1000) $display("FAIL b2b_count: got %0d want 1000", got);
        else pass_cnt++;
        total_cnt++;
        if (last - first !== 999) begin
            $display("FAIL b2b_gapless: span %0d want 999", last - first);
        end else pass_cnt++;
        total_cnt++;
        if (nrdy !== 0) $display("FAIL b2b_in_ready: low %0d times want 0", nrdy);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        logic [WIDTH-1:0] sa[4] = '{2, 100, 3328, 1234};
        logic [WIDTH-1:0] sb[4] = '{3, 100, 2, 2};
        logic [WIDTH-1:0] se[4] = '{6, 13, 3327, 2468};
        logic [TAG_W-1:0] st[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        logic [WIDTH-1:0] held_r;
        logic [TAG_W-1:0] held_t;
        logic seen = 1'b0;
        logic acc;
        int k = 0;
        int got = 0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = sa[0];
        b = sb[0];
        in_tag = st[0];
        for (int c = 0; c < 5; c++) begin
            acc = in_valid && in_ready;
            if (out_valid) begin
                total_cnt++;
                if (in_ready !== 1'b0) begin
                    $display("FAIL stall_in_ready: got %b want 0", in_ready);
                end else pass_cnt++;
                total_cnt++;
                if (!seen) begin
                    if (result !== se[0] || out_tag !== st[0]) begin
                        $display("FAIL stall_head: result=%0d tag=%h, want %0d %h",
                                 result, out_tag, se[0], st[0]);
                    end else pass_cnt++;
                    held_r = result;
                    held_t = out_tag;
                    seen = 1'b1;
                end else begin
                    if (result !== held_r || out_tag !== held_t) begin
                        $display("FAIL stall_hold: result=%0d tag=%h, want %0d %h",
                                 result, out_tag, held_r, held_t);
                    end else pass_cnt++;
                end
            end
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k < 4) begin
                    a = sa[k];
                    b = sb[k];
                    in_tag = st[k];
                end else in_valid = 1'b0;
            end
        end
        total_cnt++;
        if (k !== 3 || !seen) begin
            $display("FAIL stall_fill: accepted %0d seen %b, want 3 1", k, seen);
        end else pass_cnt++;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            acc = in_valid && in_ready;
            if (out_valid) begin
                total_cnt++;
                if (result !== se[got] || out_tag !== st[got]) begin
                    $display("FAIL stall_drain%0d: result=%0d tag=%h, want %0d %h",
                             got, result, out_tag, se[got], st[got]);
                end else pass_cnt++;
                got++;
            end
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k < 4) begin
                    a = sa[k];
                    b = sb[k];
                    in_tag = st[k];
                end else in_valid = 1'b0;
            end
        end
        total_cnt++;
        if (got !== 4 || k !== 4) begin
            $display("FAIL stall_count: results %0d accepted %0d, want 4 4", got, k);
        end else pass_cnt++;
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        logic [WIDTH-1:0] r;
        logic [TAG_W-1:0] t;
        int lat;
        logic e;
        logic stale = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = WIDTH'(10 + i);
            b = WIDTH'(20 + i);
            in_tag = TAG_W'(8'hC0 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total_cnt++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            $display("FAIL midrst_loaded: busy=%b out_valid=%b, want 1 1", busy, out_valid);
        end else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL midrst_clear: out_valid=%b busy=%b in_ready=%b, want 0 0 1",
                     out_valid, busy, in_ready);
        end else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid || busy) stale = 1'b1;
        end
        total_cnt++;
        if (stale !== 1'b0) $display("FAIL midrst_stale: got %b want 0", stale);
        else pass_cnt++;
        run_one(5, 7, 8'h77, r, t, lat, e);
        total_cnt++;
        if (r !== 35 || t !== 8'h77 || lat !== 3) begin
            $display("FAIL midrst_first: result=%0d tag=%h lat=%0d, want 35 77 3", r, t, lat);
        end else pass_cnt++;
    endtask

`ifdef MOD_MULT_RANGE_CHECK_EN
    task automatic test_range();
        int got = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 3329;
        b = 5;
        in_tag = 8'h33;
        @(posedge clk); #1;
        a = 2;
        b = 3;
        in_tag = 8'h34;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 10 && got < 2; c++) begin
            if (out_valid) begin
                total_cnt++;
                if (got == 0) begin
                    if (result !== 0 || range_err !== 1'b1 || out_tag !== 8'h33) begin
                        $display("FAIL range_bad: result=%0d err=%b tag=%h, want 0 1 33",
                                 result, range_err, out_tag);
                    end else pass_cnt++;
                end else begin
                    if (result !== 6 || range_err !== 1'b0 || out_tag !== 8'h34) begin
                        $display("FAIL range_next: result=%0d err=%b tag=%h, want 6 0 34",
                                 result, range_err, out_tag);
                    end else pass_cnt++;
                end
                got++;
            end
            @(posedge clk); #1;
        end
        total_cnt++;
        if (got !== 2) $display("FAIL range_count: got %0d want 2", got);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
`ifdef MOD_MULT_RANGE_CHECK_EN
        test_range();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
